wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Fixed priority goes to the pipeline; a wait counter forces an MDU grant after a bounded wait so the MDU cannot starve. The block sits between the writeback stage's `result`/`Write`/`next_IR` outputs and the register file write port, and drives a registered write strobe, address and data.

## Interface
Parameters:
- `MAX_WAIT`, default 4: cycles a valid MDU request may be refused before the grant is forced. Legal range 1..15.
- `WAIT_W`, default 4: width of the wait counter. Must hold `MAX_WAIT`.

Ports:
- `clk1`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pipe_valid`  in  1  writeback beat present.
- `pipe_write`  in  1  the beat writes a register (writeback `Write`).
- `pipe_rd`  in  5  destination register (`next_IR[11:7]`).
- `pipe_data`  in  32  writeback `result`.
- `pipe_ready`  out  1  the beat is consumed this cycle. Combinational.
- `mdu_valid`  in  1  MDU result present.
- `mdu_rd`  in  5  MDU destination register.
- `mdu_data`  in  32  MDU result.
- `mdu_ready`  out  1  the MDU result is consumed this cycle. Combinational.
- `rf_we`  out  1  register-file write enable. Registered.
- `rf_waddr`  out  5  write address. Registered.
- `rf_wdata`  out  32  write data. Registered.
- `mdu_hold_cnt`  out  16  saturating count of cycles with `mdu_valid & !mdu_ready`.

## Operation
Port requests:
- `pipe_req = pipe_valid & pipe_write & (pipe_rd != 0)`.
- `mdu_req = mdu_valid & (mdu_rd != 0)`.
- A valid beat that does not request the port is consumed immediately (ready=1) and produces no write.
- This covers `pipe_valid` with `pipe_write=0`, and either source with rd=x0.

FSM states:
- `PRI_PIPE` (reset state):
  - Grant the pipeline if `pipe_req`; otherwise grant the MDU if `mdu_req`.
  - A refused `mdu_valid` increments `wait_cnt`.
  - When `wait_cnt == MAX_WAIT - 1` and the MDU is refused again, the next state is `STARVED`.
- `STARVED`:
  - Grant the MDU unconditionally.
  - `pipe_ready = !pipe_req`, so a port-using pipeline beat is held and the pipeline must keep its inputs stable.
  - Next state is `PRI_PIPE` and `wait_cnt` clears.
  - `STARVED` is entered only with `mdu_valid` high. The MDU must not drop `mdu_valid` before `mdu_ready`.

Wait counter and statistics:
- `wait_cnt` clears on any MDU grant or consumption, and whenever `mdu_valid` is low.
- `mdu_hold_cnt` increments by 1 per held MDU cycle and saturates at 0xFFFF.

Write port:
- The granted source's rd and data are captured into `rf_waddr`/`rf_wdata` with `rf_we=1`.
- With no grant, `rf_we=0` and address/data hold their previous value.
- At most one write per cycle.
- Same rd from both sources: writes occur in grant order; no merging.

## Timing
- Reset values: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `mdu_hold_cnt=0`, `wait_cnt=0`, state `PRI_PIPE`.
- `pipe_ready` and `mdu_ready` are 0 during any cycle in which `rst` is high.
- Latency: a beat accepted in cycle N appears on `rf_we`/`rf_waddr`/`rf_wdata` in cycle N+1. Throughput is 1 write per cycle.
- `MAX_WAIT=4` with the pipeline writing every cycle:
  - MDU held in cycles 0..3; `STARVED` in cycle 4.
  - MDU granted in cycle 4 and its write is visible in cycle 5.
  - The pipeline is held in cycle 4 only.
- Simultaneous `pipe_req` and `mdu_req` in `PRI_PIPE`: the pipeline wins.
- Reset mid-operation:
  - Pending grants are dropped.
  - `rf_we=0` in the cycle after `rst` is sampled high.
  - Held sources re-present after reset deasserts.

## Configuration
- `WB_ARB_STARVE_EN` defined: the `STARVED` state and `wait_cnt` are present, as above.
- `WB_ARB_STARVE_EN` undefined: strict pipeline priority.
  - No `STARVED` state and no `wait_cnt`.
  - `pipe_ready` is 1 whenever `pipe_valid` is high.
  - The MDU can wait indefinitely.
  - `mdu_hold_cnt` still counts.

## Test plan
- Reset check: hold `rst` high 2 cycles with both sources valid -> `rf_we=0`, both readies 0, `mdu_hold_cnt=0`.
- Single MDU write: MDU only, `mdu_rd=5`, `mdu_data=0x1234` -> `mdu_ready=1` in cycle N; `rf_we=1`, `rf_waddr=5`, `rf_wdata=0x1234` in N+1.
- Conflict with starvation enabled: both sources valid continuously, pipeline `rd=3`, `MAX_WAIT=4`:
  - Four pipeline writes to x3 are followed by one MDU write.
  - `pipe_ready=0` for exactly that one cycle.
  - `mdu_hold_cnt=4`.
- x0 and no-write beats: `pipe_rd=0` with `pipe_write=1`, plus MDU valid `rd=7`, in the same cycle -> both readies 1; a single write to x7.
- `pipe_valid=1`, `pipe_write=0` with MDU valid -> MDU granted the same cycle; no pipeline write.
- Reset mid-hold: raise `rst` in the cycle `STARVED` is entered -> no write in the next cycle, state returns to `PRI_PIPE`, `wait_cnt=0`.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and the multi-cycle multiply/divide unit (MDU). The
// pipeline has fixed priority. The write strobe, address and data are
// registered, so a beat accepted in cycle N is written in cycle N+1.
//
// Optional feature macro: WB_ARB_STARVE_EN
//   defined   : anti-starvation FSM (PRI_PIPE / STARVED) with a wait
//               counter. After MAX_WAIT consecutive refusals the MDU gets
//               the next cycle unconditionally.
//   undefined : strict pipeline priority. The MDU may wait indefinitely.
//
// Handshake (both sources): a beat is offered with *_valid and is consumed
// in every cycle where *_valid and *_ready are both high. A source whose
// beat is not consumed must hold valid and its payload stable into the
// next cycle. A valid beat that does not need the port (pipeline not
// writing, or rd == x0) is consumed at once and produces no write. Both
// readies are forced low while rst is high, so held sources re-present
// after reset.
module wb_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic        pipe_write,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_ready,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [15:0] mdu_hold_cnt
);

    // Reject parameter sets the wait counter cannot represent.
    if (MAX_WAIT < 1 || MAX_WAIT > 15 || MAX_WAIT >= (1 << WAIT_W)) begin : g_bad_cfg
        $error("wb_port_arbiter: MAX_WAIT must be 1..15 and fit in WAIT_W bits");
    end

    // A source needs the write port only when it carries a real register write.
    logic pipe_req;
    logic mdu_req;
    logic pipe_gnt;
    logic mdu_gnt;

    assign pipe_req = pipe_valid & pipe_write & (pipe_rd != 5'd0);
    assign mdu_req  = mdu_valid & (mdu_rd != 5'd0);

`ifdef WB_ARB_STARVE_EN

    typedef enum logic [0:0] {
        PRI_PIPE = 1'b0,
        STARVED  = 1'b1
    } arb_state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              mdu_refused;

    // State register and wait counter; reset returns to pipeline priority.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= PRI_PIPE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Grant selection, readies and next state for the anti-starvation FSM.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pipe_gnt     = 1'b0;
        mdu_gnt      = 1'b0;
        pipe_ready   = 1'b0;
        mdu_ready    = 1'b0;
        mdu_refused  = 1'b0;
        if (!rst) begin
            case (state)
                PRI_PIPE: begin
                    // Pipeline first; the MDU only loses when both need the port.
                    pipe_gnt    = pipe_req;
                    mdu_gnt     = mdu_req & ~pipe_req;
                    pipe_ready  = pipe_valid;
                    mdu_ready   = mdu_valid & ~(mdu_req & pipe_req);
                    mdu_refused = mdu_valid & ~mdu_ready;
                    if (mdu_refused) begin
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_LAST) begin
                            state_nxt = STARVED;
                        end
                    end else begin
                        wait_cnt_nxt = '0;
                    end
                end
                STARVED: begin
                    // Entered only with mdu_valid high; the MDU owns this cycle
                    // and a port-using pipeline beat is held back.
                    mdu_gnt      = mdu_req;
                    mdu_ready    = mdu_valid;
                    pipe_ready   = pipe_valid & ~pipe_req;
                    state_nxt    = PRI_PIPE;
                    wait_cnt_nxt = '0;
                end
                default: begin
                    state_nxt    = PRI_PIPE;
                    wait_cnt_nxt = '0;
                end
            endcase
        end
    end

`else

    // Strict pipeline priority: the pipeline is never held back.
    always_comb begin
        pipe_gnt   = 1'b0;
        mdu_gnt    = 1'b0;
        pipe_ready = 1'b0;
        mdu_ready  = 1'b0;
        if (!rst) begin
            pipe_gnt   = pipe_req;
            mdu_gnt    = mdu_req & ~pipe_req;
            pipe_ready = pipe_valid;
            mdu_ready  = mdu_valid & ~(mdu_req & pipe_req);
        end
    end

`endif

    // Registered write port: capture the granted source, otherwise drop the
    // strobe and keep the last address/data.
    always_ff @(posedge clk1) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (pipe_gnt) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_rd;
            rf_wdata <= pipe_data;
        end else if (mdu_gnt) begin
            rf_we    <= 1'b1;
            rf_waddr <= mdu_rd;
            rf_wdata <= mdu_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Saturating count of cycles in which an MDU result waits unconsumed.
    always_ff @(posedge clk1) begin
        if (rst) begin
            mdu_hold_cnt <= 16'd0;
        end else if (mdu_valid && !mdu_ready && mdu_hold_cnt != 16'hFFFF) begin
            mdu_hold_cnt <= mdu_hold_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//
// Bench for wb_port_arbiter. A behavioural model tracks how many consecutive
// cycles the MDU has been refused and derives grants, readies and the
// expected register-file writes from the arbitration rules; one compare
// process checks the DUT against it every cycle. Directed sequences pin the
// model with hand-computed values, then randomized traffic (with random
// resets) follows. Follows WB_ARB_STARVE_EN exactly like the design.
module tb_wb_port_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = 4;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk1;
  logic        rst;
  logic        pipe_valid;
  logic        pipe_write;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] mdu_hold_cnt;

  wb_port_arbiter #(
    .MAX_WAIT(MAX_WAIT),
    .WAIT_W  (WAIT_W)
  ) dut (
    .clk1        (clk1),
    .rst         (rst),
    .pipe_valid  (pipe_valid),
    .pipe_write  (pipe_write),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .pipe_ready  (pipe_ready),
    .mdu_valid   (mdu_valid),
    .mdu_rd      (mdu_rd),
    .mdu_data    (mdu_data),
    .mdu_ready   (mdu_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .mdu_hold_cnt(mdu_hold_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and check helper ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [36:0] exp_q[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  int          m_hold = 0;
  int          m_run  = 0;

  initial begin
    logic [36:0] e;
    bit preq, mreq, starved, p_take, m_take, w_en;
    logic [4:0]  w_a;
    logic [31:0] w_d;
    @(posedge clk1);
    forever begin
      @(negedge clk1);
      // registered outputs reflect the previous cycle's decision
      chk("rf_we", rf_we, m_we);
      chk("rf_waddr", rf_waddr, m_addr);
      chk("rf_wdata", rf_wdata, m_data);
      chk("mdu_hold_cnt", mdu_hold_cnt, m_hold);
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_write: got write x%0d=0x%0h, required no write at %0t", rf_waddr, rf_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_write", {rf_waddr, rf_wdata}, e);
        end
      end
      // decide this cycle from the arbitration rules
      preq    = pipe_valid && pipe_write && (pipe_rd != 0);
      mreq    = mdu_valid && (mdu_rd != 0);
      starved = STARVE_EN && (m_run >= MAX_WAIT);
      w_en = 0; w_a = 0; w_d = 0;
      if (rst) begin
        p_take = 0; m_take = 0;
      end else if (starved) begin
        m_take = mdu_valid;
        p_take = pipe_valid && !preq;
        if (mreq) begin w_en = 1; w_a = mdu_rd; w_d = mdu_data; end
      end else if (preq) begin
        p_take = 1;
        m_take = mdu_valid && !mreq;
        w_en = 1; w_a = pipe_rd; w_d = pipe_data;
      end else if (mreq) begin
        p_take = pipe_valid;
        m_take = 1;
        w_en = 1; w_a = mdu_rd; w_d = mdu_data;
      end else begin
        p_take = pipe_valid;
        m_take = mdu_valid;
      end
      chk("pipe_ready", pipe_ready, p_take);
      chk("mdu_ready", mdu_ready, m_take);
      // advance the model to the next cycle
      if (rst) begin
        m_we = 0; m_addr = 0; m_data = 0; m_hold = 0; m_run = 0;
        exp_q.delete();
      end else begin
        m_we = w_en;
        if (w_en) begin
          m_addr = w_a;
          m_data = w_d;
          exp_q.push_back({w_a, w_d});
        end
        if (mdu_valid && !m_take) begin
          m_run++;
          if (m_hold < 65535) m_hold++;
        end else begin
          m_run = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic half();
    @(negedge clk1);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v; pipe_write = w; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mdu_valid = v; mdu_rd = rd; mdu_data = d;
  endtask

  // Both sources valid for five cycles; starvation shows up in cycle 4.
  task automatic conflict_run(input logic [4:0] m_rd, input string tag);
    int held;
    bit starve_cycle;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      starve_cycle = STARVE_EN && (i == MAX_WAIT);
      half();
      chk({tag, "_pipe_ready"}, pipe_ready, !starve_cycle);
      chk({tag, "_mdu_ready"}, mdu_ready, starve_cycle);
      if (pipe_ready !== 1'b1) held++;
      step();
      chk({tag, "_rf_we"}, rf_we, 1);
      chk({tag, "_rf_waddr"}, rf_waddr, starve_cycle ? m_rd : 5'd3);
    end
    chk({tag, "_pipe_held_cycles"}, held, STARVE_EN ? 1 : 0);
    chk({tag, "_hold_cnt"}, mdu_hold_cnt, STARVE_EN ? 4 : 5);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit p_rdy, m_rdy;
    rst = 1'b1;
    set_pipe(1, 1, 5'd3, 32'h1111_0000);
    set_mdu(1, 5'd5, 32'h2222_0000);

    // reset held two cycles with both sources valid
    half();
    chk("rst_pipe_ready", pipe_ready, 0);
    chk("rst_mdu_ready", mdu_ready, 0);
    step();
    half();
    chk("rst_pipe_ready2", pipe_ready, 0);
    chk("rst_mdu_ready2", mdu_ready, 0);
    step();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_hold_cnt", mdu_hold_cnt, 0);
    chk("rst_rf_waddr", rf_waddr, 0);

    // single MDU write
    rst = 1'b0;
    set_pipe(0, 0, 5'd0, 32'd0);
    set_mdu(1, 5'd5, 32'h1234);
    half();
    chk("mdu_only_ready", mdu_ready, 1);
    step();
    set_mdu(0, 5'd0, 32'd0);
    chk("mdu_only_we", rf_we, 1);
    chk("mdu_only_waddr", rf_waddr, 5);
    chk("mdu_only_wdata", rf_wdata, 32'h1234);

    // conflict: pipeline x3 every cycle, MDU x9 waiting
    set_pipe(1, 1, 5'd3, 32'hA3A3_0003);
    set_mdu(1, 5'd9, 32'h9999);
    conflict_run(5'd9, "conflict");
    set_pipe(0, 0, 5'd0, 32'd0);
    set_mdu(0, 5'd0, 32'd0);
    step();

    // pipeline writes x0 while MDU writes x7
    set_pipe(1, 1, 5'd0, 32'hDEAD);
    set_mdu(1, 5'd7, 32'h77);
    half();
    chk("x0_pipe_ready", pipe_ready, 1);
    chk("x0_mdu_ready", mdu_ready, 1);
    step();
    set_pipe(0, 0, 5'd0, 32'd0);
    set_mdu(0, 5'd0, 32'd0);
    chk("x0_we", rf_we, 1);
    chk("x0_waddr", rf_waddr, 7);
    chk("x0_wdata", rf_wdata, 32'h77);
    step();
    chk("x0_single_write", rf_we, 0);

    // pipeline beat without a write, MDU x6
    set_pipe(1, 0, 5'd4, 32'h4444);
    set_mdu(1, 5'd6, 32'h66);
    half();
    chk("nowr_pipe_ready", pipe_ready, 1);
    chk("nowr_mdu_ready", mdu_ready, 1);
    step();
    set_pipe(0, 0, 5'd0, 32'd0);
    set_mdu(0, 5'd0, 32'd0);
    chk("nowr_we", rf_we, 1);
    chk("nowr_waddr", rf_waddr, 6);
    chk("nowr_wdata", rf_wdata, 32'h66);

    // reset in the cycle the starvation grant would happen
    set_pipe(1, 1, 5'd3, 32'h3333);
    set_mdu(1, 5'd10, 32'hAAAA);
    repeat (MAX_WAIT) step();
    rst = 1'b1;
    half();
    chk("midrst_pipe_ready", pipe_ready, 0);
    chk("midrst_mdu_ready", mdu_ready, 0);
    step();
    rst = 1'b0;
    chk("midrst_we", rf_we, 0);
    conflict_run(5'd10, "after_rst");
    set_pipe(0, 0, 5'd0, 32'd0);
    set_mdu(0, 5'd0, 32'd0);

    // long conflict to reach the hold counter saturation
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_pipe(1, 1, 5'd3, 32'h5A5A);
    set_mdu(1, 5'd11, 32'hBBBB);
    repeat (65540) step();
    chk("sat_hold_cnt", mdu_hold_cnt, STARVE_EN ? 52432 : 65535);
    set_pipe(0, 0, 5'd0, 32'd0);
    set_mdu(0, 5'd0, 32'd0);
    step();

    // randomized traffic; unconsumed beats stay stable
    for (int c = 0; c < 3000; c++) begin
      half();
      p_rdy = pipe_ready;
      m_rdy = mdu_ready;
      step();
      rst = ($urandom_range(0, 49) == 0);
      if (!pipe_valid || p_rdy)
        set_pipe($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      if (!mdu_valid || m_rdy)
        set_mdu($urandom_range(0, 9) < 6,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end
    rst = 1'b0;
    set_pipe(0, 0, 5'd0, 32'd0);
    set_mdu(0, 5'd0, 32'd0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
